// File: rtl/calc_sequencer.sv
// Operand entry and add/subtract sequencing for a shared carry-in-less ripple adder.
// Define CALC_CHAIN_EN to load the previous result into operand A on the enter that leaves DONE.
module calc_sequencer #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_n,
   input  logic [WIDTH-1:0] sw_i,
   input  logic             op_sub_i,
   input  logic [WIDTH:0]   adder_sum_i,
   output logic [WIDTH-1:0] adder_a_o,
   output logic [WIDTH-1:0] adder_b_o,
   output logic [WIDTH:0]   result_o,
   output logic             neg_o,
   output logic             result_valid_o,
   output logic             busy_o,
   output logic [2:0]       state_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_GET_B = 3'd1,
      S_NEG   = 3'd2,
      S_ADD   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                 state, state_nx;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   key_prev, enter;
   logic [WIDTH-1:0]       a_q, a_src, a_nx, b_nx;
   logic                   op_q, c1_q, sub_neg;
   logic                   ld_a, ld_b, cap_neg, cap_sum, clr_valid;

   // Synchronizer idles high (released key) so reset release never fakes a strike.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '1;
         key_prev <= 1'b1;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], key_n};
         key_prev <= sync_q[SYNC_STAGES-1];
      end
   end

   assign enter = key_prev & ~sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Adder operands are computed for the state being entered; B and -B live only
   // in the operand registers, which is all the sequence ever reads them from.
   always_comb begin
      state_nx  = state;
      ld_a      = 1'b0;
      ld_b      = 1'b0;
      cap_neg   = 1'b0;
      cap_sum   = 1'b0;
      clr_valid = 1'b0;
      a_nx      = '0;
      b_nx      = '0;
      case (state)
         S_IDLE: if (enter) begin
            ld_a     = 1'b1;
            state_nx = S_GET_B;
         end
         S_GET_B: if (enter) begin
            ld_b = 1'b1;
            if (op_sub_i) begin
               state_nx = S_NEG;
               a_nx     = ~sw_i;
               b_nx     = WIDTH'(1);
            end else begin
               state_nx = S_ADD;
               a_nx     = a_q;
               b_nx     = sw_i;
            end
         end
         S_NEG: begin
            cap_neg  = 1'b1;
            state_nx = S_ADD;
            a_nx     = a_q;
            b_nx     = adder_sum_i[WIDTH-1:0];
         end
         S_ADD: begin
            cap_sum  = 1'b1;
            state_nx = S_DONE;
         end
         S_DONE: if (enter) begin
            clr_valid = 1'b1;
`ifdef CALC_CHAIN_EN
            ld_a      = 1'b1;
            state_nx  = S_GET_B;
`else
            state_nx  = S_IDLE;
`endif
         end
         default: state_nx = S_IDLE;
      endcase
   end

`ifdef CALC_CHAIN_EN
   assign a_src = (state == S_DONE) ? result_o[WIDTH-1:0] : sw_i;
`else
   assign a_src = sw_i;
`endif

   // Carry from A + (-B) or from negating B=0 means the difference is non-negative.
   assign sub_neg = ~(adder_sum_i[WIDTH] | c1_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q            <= '0;
         op_q           <= 1'b0;
         c1_q           <= 1'b0;
         adder_a_o      <= '0;
         adder_b_o      <= '0;
         result_o       <= '0;
         neg_o          <= 1'b0;
         result_valid_o <= 1'b0;
      end else begin
         adder_a_o <= a_nx;
         adder_b_o <= b_nx;
         if (ld_a)    a_q  <= a_src;
         if (ld_b)    op_q <= op_sub_i;
         if (cap_neg) c1_q <= adder_sum_i[WIDTH];
         if (cap_sum) begin
            result_valid_o <= 1'b1;
            if (op_q) begin
               neg_o    <= sub_neg;
               result_o <= {sub_neg, adder_sum_i[WIDTH-1:0]};
            end else begin
               neg_o    <= 1'b0;
               result_o <= adder_sum_i;
            end
         end else if (clr_valid) begin
            result_valid_o <= 1'b0;
         end
      end
   end

   assign busy_o  = (state == S_NEG) || (state == S_ADD);
   assign state_o = state;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: operation-level model compared every cycle,
// directed literal cases, then randomized key/switch/reset traffic.
module tb_calc_sequencer;
   localparam int W = 4;
   localparam int S = 2;

   logic         clk = 1'b0, rst_n = 1'b0, key_n = 1'b1, op_sub = 1'b0;
   logic [W-1:0] sw = '0, adder_a, adder_b;
   logic [W:0]   adder_sum, result;
   logic         neg, valid, busy;
   logic [2:0]   state;

   int checks = 0, errors = 0, cyc = 0;
   int busy_cyc = 0, val_cyc = 0;
   logic [W-1:0] add_a = '0, add_b = '0;
   logic busy_q = 1'b0, valid_q = 1'b0;

   // model state: ph 0=waiting A, 1=waiting B, 2=computing (left cycles), 3=result shown
   bit           hist [S+1];
   bit           m_en;
   int           ph = 0, left = 0;
   logic [W-1:0] mA = '0, mB = '0;
   logic         mop = 1'b0, mneg = 1'b0, mvalid = 1'b0;
   logic [W:0]   mres = '0;
   logic [2:0]   e_state;
   logic [W-1:0] ea, eb;

   assign adder_sum = {1'b0, adder_a} + {1'b0, adder_b};
   always #5 clk = ~clk;

   calc_sequencer #(.WIDTH(W), .SYNC_STAGES(S)) dut (
      .clk(clk), .rst_n(rst_n), .key_n(key_n), .sw_i(sw), .op_sub_i(op_sub),
      .adder_sum_i(adder_sum), .adder_a_o(adder_a), .adder_b_o(adder_b),
      .result_o(result), .neg_o(neg), .result_valid_o(valid), .busy_o(busy),
      .state_o(state)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // behavioural model, advanced once per rising edge
   initial begin
      for (int j = 0; j <= S; j++) hist[j] = 1'b1;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            for (int j = 0; j <= S; j++) hist[j] = 1'b1;
            ph = 0; left = 0; mA = '0; mB = '0; mop = 1'b0;
            mres = '0; mneg = 1'b0; mvalid = 1'b0;
         end else begin
            m_en = hist[S] && !hist[S-1];
            for (int j = S; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = key_n;
            case (ph)
               0: if (m_en) begin mA = sw; ph = 1; end
               1: if (m_en) begin mB = sw; mop = op_sub; left = op_sub ? 2 : 1; ph = 2; end
               2: begin
                  left--;
                  if (left == 0) begin
                     if (mop) begin
                        mres = (W+1)'(int'(mA) - int'(mB));
                        mneg = (mA < mB);
                     end else begin
                        mres = (W+1)'(int'(mA) + int'(mB));
                        mneg = 1'b0;
                     end
                     mvalid = 1'b1;
                     ph = 3;
                  end
               end
               default: if (m_en) begin
                  mvalid = 1'b0;
`ifdef CALC_CHAIN_EN
                  mA = mres[W-1:0];
                  ph = 1;
`else
                  ph = 0;
`endif
               end
            endcase
         end
      end
   end

   // per-cycle compare against the model, plus latency/operand monitors
   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         e_state = (ph == 0) ? 3'd0 : (ph == 1) ? 3'd1 : (ph == 3) ? 3'd4 :
                   (mop && left == 2) ? 3'd2 : 3'd3;
         ea = '0; eb = '0;
         if (e_state == 3'd2) begin
            ea = ~mB; eb = W'(1);
         end else if (e_state == 3'd3) begin
            ea = mA; eb = mop ? W'((1 << W) - int'(mB)) : mB;
         end
         chk("state", state, e_state);
         chk("busy", busy, (ph == 2));
         chk("valid", valid, mvalid);
         chk("result", result, mres);
         chk("neg", neg, mneg);
         chk("adder_a", adder_a, ea);
         chk("adder_b", adder_b, eb);
         if (busy && !busy_q) busy_cyc = cyc;
         if (valid && !valid_q) val_cyc = cyc;
         if (state == 3'd3) begin add_a = adder_a; add_b = adder_b; end
         busy_q = busy;
         valid_q = valid;
      end
   end

   task automatic press();
      @(negedge clk) key_n = 1'b0;
      repeat (3) @(negedge clk);
      key_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk) rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         key_n = 1'($urandom); sw = W'($urandom);
      end
      @(posedge clk); #2;
      chk("reset state", state, 0);
      chk("reset valid", valid, 0);
      chk("reset result", result, 0);
      chk("reset adder_a", adder_a, 0);
      @(negedge clk) begin key_n = 1'b1; rst_n = 1'b1; end
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_valid(input string nm);
      int i;
      for (i = 0; i < 20; i++) begin
         @(posedge clk); #2;
         if (valid) break;
      end
      if (i == 20) chk({nm, " timeout"}, 0, 1);
   endtask

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic [W:0] er, input logic en, input string nm);
      do_reset();
      sw = a;
      press();
      chk({nm, " got A"}, state, 1);
      sw = b; op_sub = sub;
      @(negedge clk) key_n = 1'b0;
      repeat (3) @(negedge clk);
      key_n = 1'b1; sw = W'($urandom); op_sub = 1'($urandom);
      wait_valid(nm);
      chk({nm, " result"}, result, er);
      chk({nm, " neg"}, neg, en);
      chk({nm, " done state"}, state, 4);
      chk({nm, " latency"}, val_cyc - busy_cyc, sub ? 2 : 1);
   endtask

   initial begin
      do_reset();

      do_op(4'd9, 4'd7, 1'b0, 5'd16, 1'b0, "add 9+7");
      chk("add opA", add_a, 9);
      chk("add opB", add_b, 7);
      press();
`ifdef CALC_CHAIN_EN
      chk("done enter", state, 1);
`else
      chk("done enter", state, 0);
`endif
      chk("done clears valid", valid, 0);

      do_op(4'd3, 4'd5, 1'b1, 5'd30, 1'b1, "sub 3-5");
      do_op(4'd5, 4'd3, 1'b1, 5'd2,  1'b0, "sub 5-3");
      do_op(4'd6, 4'd0, 1'b1, 5'd6,  1'b0, "sub 6-0");
      do_op(4'd15, 4'd15, 1'b0, 5'd30, 1'b0, "add 15+15");

      // second enter strike lands while the subtract is still busy
      do_reset();
      sw = 4'd9; press();
      sw = 4'd4; op_sub = 1'b1;
      @(negedge clk) key_n = 1'b0;
      @(negedge clk) key_n = 1'b1;
      @(negedge clk) key_n = 1'b0;
      @(negedge clk) begin key_n = 1'b1; sw = W'($urandom); end
      wait_valid("ignore");
      chk("ignore result", result, 5);
      chk("ignore state", state, 4);
      chk("ignore latency", val_cyc - busy_cyc, 2);

      // reset while in NEG
      do_reset();
      sw = 4'd7; press();
      sw = 4'd2; op_sub = 1'b1;
      @(negedge clk) key_n = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #2;
         if (state == 3'd2) break;
      end
      chk("abort in NEG", state, 2);
      @(negedge clk) begin rst_n = 1'b0; key_n = 1'b1; end
      @(posedge clk); #2;
      chk("abort state", state, 0);
      chk("abort valid", valid, 0);
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(negedge clk);

`ifdef CALC_CHAIN_EN
      do_op(4'd4, 4'd5, 1'b0, 5'd9, 1'b0, "chain 4+5");
      press();
      chk("chain to GET_B", state, 1);
      sw = 4'd3; op_sub = 1'b0;
      press();
      wait_valid("chain");
      chk("chain result", result, 12);
      chk("chain opA", add_a, 9);
`endif

      // randomized traffic including key bounce and occasional reset
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         if ($urandom_range(3) == 0) key_n = ~key_n;
         sw = W'($urandom);
         op_sub = 1'($urandom);
         rst_n = ($urandom_range(249) != 0);
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
